// File: rtl/rf_pkg.sv
// Shared constants, types and helpers for the register-file write-back scheduler.
package rf_pkg;
  localparam int NREQ     = 3;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 4;
  localparam int LANES    = 2;
  localparam int NREGS    = 24;
  localparam int SCA_REGS = 16;
  localparam int VEC_BASE = 16;

  typedef logic [DATA_W-1:0]            sca_t;
  typedef logic [LANES-1:0][DATA_W-1:0] vec_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    sca_t              sca;
    vec_t              vec;
  } wb_req_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(NREGS);
  endfunction

  function automatic logic is_vec(input logic [ADDR_W-1:0] addr);
    return (addr >= ADDR_W'(VEC_BASE)) && (addr < ADDR_W'(NREGS));
  endfunction
endpackage

// File: rtl/rf_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr, gidx;
  logic          found;
  int            idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[PW'(idx)]) begin
        grant[PW'(idx)] = 1'b1;
        gidx            = PW'(idx);
        found           = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       ptr <= '0;
    else if (found) ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
  end
endmodule

// File: rtl/rf_wb_scheduler.sv
// Write-back port scheduler with pending-write scoreboard.
// Optional RF_WB_BYPASS_EN exposes the staged write as a forwarding path.
module rf_wb_scheduler
  import rf_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ-1:0][ADDR_W-1:0]   req_addr,
  input  sca_t [NREQ-1:0]               req_sca,
  input  vec_t [NREQ-1:0]               req_vec,
  output logic                          rf_we,
  output logic [ADDR_W-1:0]             rf_a3,
  output sca_t                          rf_wd_sca,
  output vec_t                          rf_wd_vec,
  input  logic                          iss_set,
  input  logic [ADDR_W-1:0]             iss_addr,
  input  logic [ADDR_W-1:0]             q_addr1,
  input  logic [ADDR_W-1:0]             q_addr2,
  output logic                          busy1,
  output logic                          busy2,
  output logic                          stall,
`ifdef RF_WB_BYPASS_EN
  output logic                          byp_hit1,
  output logic                          byp_hit2,
  output sca_t                          byp_sca,
  output vec_t                          byp_vec,
`endif
  output logic                          err
);
  logic [NREQ-1:0]  grant;
  logic             fire;
  wb_req_t          sel;
  logic [NREGS-1:0] busy, busy_nxt;
  logic             raw1, raw2, iss_busy;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign fire      = |grant;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) sel = '{addr: req_addr[i], sca: req_sca[i], vec: req_vec[i]};
  end

  // Out-of-range writes are consumed but never reach the file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we     <= 1'b0;
      rf_a3     <= '0;
      rf_wd_sca <= '0;
      rf_wd_vec <= '0;
      err       <= 1'b0;
    end else begin
      rf_we <= fire && in_range(sel.addr);
      if (fire) begin
        if (in_range(sel.addr)) begin
          rf_a3     <= sel.addr;
          rf_wd_sca <= is_vec(sel.addr) ? '0 : sel.sca;
          rf_wd_vec <= is_vec(sel.addr) ? sel.vec : '0;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  // Clear first so a same-edge set of the committed register wins.
  always_comb begin
    busy_nxt = busy;
    if (rf_we && in_range(rf_a3))       busy_nxt[rf_a3]    = 1'b0;
    if (iss_set && in_range(iss_addr)) busy_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  assign raw1     = in_range(q_addr1)  && busy[q_addr1];
  assign raw2     = in_range(q_addr2)  && busy[q_addr2];
  assign iss_busy = in_range(iss_addr) && busy[iss_addr];

`ifdef RF_WB_BYPASS_EN
  assign byp_hit1 = rf_we && (rf_a3 == q_addr1);
  assign byp_hit2 = rf_we && (rf_a3 == q_addr2);
  assign byp_sca  = rf_wd_sca;
  assign byp_vec  = rf_wd_vec;
  assign busy1    = raw1 && !byp_hit1;
  assign busy2    = raw2 && !byp_hit2;
`else
  assign busy1    = raw1;
  assign busy2    = raw2;
`endif

  assign stall = busy1 | busy2 | (iss_set & iss_busy);
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: arbitration, output stage, scoreboard, error and reset.
module tb_rf_wb_scheduler;
  import rf_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  sca_t [NREQ-1:0]             req_sca;
  vec_t [NREQ-1:0]             req_vec;
  logic                        rf_we;
  logic [ADDR_W-1:0]           rf_a3;
  sca_t                        rf_wd_sca;
  vec_t                        rf_wd_vec;
  logic                        iss_set;
  logic [ADDR_W-1:0]           iss_addr, q_addr1, q_addr2;
  logic                        busy1, busy2, stall, err;
`ifdef RF_WB_BYPASS_EN
  logic                        byp_hit1, byp_hit2;
  sca_t                        byp_sca;
  vec_t                        byp_vec;
`endif

  int total = 0;
  int pass  = 0;

  rf_wb_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_sca(req_sca), .req_vec(req_vec),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd_sca(rf_wd_sca), .rf_wd_vec(rf_wd_vec),
    .iss_set(iss_set), .iss_addr(iss_addr), .q_addr1(q_addr1), .q_addr2(q_addr2),
    .busy1(busy1), .busy2(busy2), .stall(stall),
`ifdef RF_WB_BYPASS_EN
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_sca(byp_sca), .byp_vec(byp_vec),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [NREQ-1:0]   exp_gnt [4];
  logic [ADDR_W-1:0] exp_a3  [4];

  initial begin
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_a3  = '{5'd2, 5'd16, 5'd3, 5'd2};
    rst = 1'b0; req_valid = '0; req_addr = '0; req_sca = '0; req_vec = '0;
    iss_set = 1'b0; iss_addr = '0; q_addr1 = 5'd5; q_addr2 = 5'd6;
    #12;
    chk("reset_we", rf_we, 0);
    chk("reset_a3", rf_a3, 0);
    chk("reset_sca", rf_wd_sca, 0);
    chk("reset_vec", rf_wd_vec, 0);
    chk("reset_err", err, 0);
    chk("reset_busy1", busy1, 0);
    rst = 1'b1;

    // single scalar write
    req_valid = 3'b001; req_addr[0] = 5'd1; req_sca[0] = 4'hF;
    #1 chk("single_ready", req_ready, 3'b001);
    tick(); req_valid = '0;
    chk("single_we", rf_we, 1);
    chk("single_a3", rf_a3, 1);
    chk("single_sca", rf_wd_sca, 4'hF);
    chk("single_vec", rf_wd_vec, 0);
    tick();
    chk("single_we_drop", rf_we, 0);

    // vector write from req1 (ptr is 1)
    req_valid = 3'b010; req_addr[1] = 5'd17; req_vec[1] = 8'hCA; req_sca[1] = 4'h5;
    #1 chk("vec_ready", req_ready, 3'b010);
    tick(); req_valid = '0;
    chk("vec_a3", rf_a3, 17);
    chk("vec_data", rf_wd_vec, 8'hCA);
    chk("vec_sca_zero", rf_wd_sca, 0);

    // req2 write moves ptr back to 0
    req_valid = 3'b100; req_addr[2] = 5'd4; req_sca[2] = 4'h7;
    #1 chk("r2_ready", req_ready, 3'b100);
    tick(); req_valid = '0;
    chk("r2_sca", rf_wd_sca, 4'h7);

    // round robin with all three valid
    req_addr[0] = 5'd2; req_addr[1] = 5'd16; req_addr[2] = 5'd3;
    req_valid = 3'b111;
    for (int c = 0; c < 4; c++) begin
      #1 chk($sformatf("rr_grant%0d", c), req_ready, exp_gnt[c]);
      tick();
      chk($sformatf("rr_a3_%0d", c), rf_a3, exp_a3[c]);
      chk($sformatf("rr_we_%0d", c), rf_we, 1);
    end
    req_valid = '0;
    tick();
    chk("rr_idle_we", rf_we, 0);

    // scoreboard set, query, clear (ptr is 1; only req0 valid)
    iss_set = 1'b1; iss_addr = 5'd5;
    #1 chk("sb_stall_pre", stall, 0);
    tick(); iss_set = 1'b0;
    chk("sb_busy1", busy1, 1);
    chk("sb_busy2", busy2, 0);
    chk("sb_stall", stall, 1);
    req_valid = 3'b001; req_addr[0] = 5'd5; req_sca[0] = 4'h3;
    #1 chk("sb_wb_ready", req_ready, 3'b001);
    tick(); req_valid = '0;
    chk("sb_wb_a3", rf_a3, 5);
`ifdef RF_WB_BYPASS_EN
    chk("byp_hit1", byp_hit1, 1);
    chk("byp_busy1", busy1, 0);
    chk("byp_sca", byp_sca, 4'h3);
`else
    chk("sb_busy_n1", busy1, 1);
`endif
    tick();
    chk("sb_busy_n2", busy1, 0);
    chk("sb_stall_n2", stall, 0);

    // set and clear of register 5 on the same edge
    iss_set = 1'b1; iss_addr = 5'd5;
    tick(); iss_set = 1'b0;
    req_valid = 3'b001;
    tick(); req_valid = '0;
    chk("col_we", rf_we, 1);
    iss_set = 1'b1; iss_addr = 5'd5;
    #1 chk("col_stall", stall, 1);
    tick(); iss_set = 1'b0;
    chk("col_busy", busy1, 1);

    // out-of-range address (ptr is 1)
    req_valid = 3'b010; req_addr[1] = 5'd30;
    #1 chk("bad_ready", req_ready, 3'b010);
    tick(); req_valid = '0;
    chk("bad_we", rf_we, 0);
    chk("bad_err", err, 1);
    tick();
    chk("bad_err_sticky", err, 1);

    // reset while a write is staged
    req_valid = 3'b001; req_addr[0] = 5'd7; req_sca[0] = 4'h9;
    iss_set = 1'b1; iss_addr = 5'd7; q_addr1 = 5'd7;
    tick(); req_valid = '0; iss_set = 1'b0;
    chk("rst_pre_we", rf_we, 1);
    chk("rst_pre_busy", busy1, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_a3", rf_a3, 0);
    chk("rst_sca", rf_wd_sca, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy1, 0);
    rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Write-back scheduler for the scalar/vector register file: arbitrates the single register-file write port (WE, A3_WB, WD3_SCA, WD3_VEC) between three write-back sources (scalar ALU, vector ALU, load unit) using round-robin valid/ready handshakes. It also keeps a 24-bit pending-write scoreboard that the issue stage queries to stall on RAW/WAW hazards. It sits between the execute/memory stages and the register file, and drives the file's write inputs directly.

## Interface
- NREQ, 3, number of write-back requesters (0 = scalar ALU, 1 = vector ALU, 2 = load unit)
- ADDR_W, 5, register address width
- DATA_W, 4, scalar element width
- LANES, 2, vector lanes
- NREGS, 24, implemented registers (R0–R15 scalar, R16–R23 vector)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-low
- req_valid  in  NREQ  write-back request valid, one bit per requester
- req_ready  out  NREQ  grant; the transfer occurs when valid & ready
- req_addr  in  NREQ×ADDR_W  destination register, per requester
- req_sca  in  NREQ×DATA_W  scalar data, per requester
- req_vec  in  NREQ×LANES×DATA_W  vector data, per requester
- rf_we  out  1  register-file write enable
- rf_a3  out  ADDR_W  register-file write address
- rf_wd_sca  out  DATA_W  scalar write data
- rf_wd_vec  out  LANES×DATA_W  vector write data
- iss_set  in  1  issue stage marks a destination as pending
- iss_addr  in  ADDR_W  destination being marked
- q_addr1, q_addr2  in  ADDR_W  source registers to check
- busy1, busy2  out  1  pending-write status for q_addr1 and q_addr2 (combinational)
- stall  out  1  busy1 | busy2 | (iss_set & busy[iss_addr])
- err  out  1  sticky flag: a write-back targeted an address ≥ NREGS

## Operation
- **Arbitration.** Round-robin with priority pointer `ptr`, reset value 0.
  - The first valid requester at or after `ptr` (mod NREQ) is granted; `req_ready` is one-hot or zero.
  - After a grant to requester i, `ptr` becomes (i+1) mod NREQ. With no grant, `ptr` is unchanged.
  - `req_ready` depends combinationally on `req_valid`, so requesters must not derive valid from ready.
  - Data and address must be held stable while valid is high and ready is low.
- **Output stage.** A single register stage; the file always accepts, so throughput is one write per cycle.
  - Address < 16: load `rf_wd_sca` from `req_sca` and set `rf_wd_vec` = 0.
  - Address 16–23: load `rf_wd_vec` from `req_vec` and set `rf_wd_sca` = 0.
  - Address ≥ 24: the request is accepted (ready asserted), `rf_we` stays 0, and `err` sets.
- **Scoreboard.** `busy[NREGS]` bit vector.
  - Set on `iss_set` (ignored when `iss_addr` ≥ NREGS).
  - Cleared at the edge that ends a cycle with `rf_we`=1 for `rf_a3`.
  - Set and clear of the same register on the same edge: set wins.
  - A query address ≥ NREGS reads as not busy.
- **Reset values.** `rf_we`=0, `rf_a3`=0, both data outputs 0, `busy`=0, `err`=0, `ptr`=0.
  - Reset mid-operation discards the staged write: it is not committed, and its busy bit is cleared.

## Timing
- Handshake sampled at edge N; `rf_we`/`rf_a3`/data are valid during cycle N+1; the register file commits at edge N+1.
- `busy` clears at edge N+1, so the issue stage sees `busy`=0 and new RF read data together in cycle N+2.
- Back-to-back grants are allowed every cycle; three continuously valid requesters are served 0,1,2,0,…
- `busy`, `stall` and `req_ready` are combinational from the current state and inputs; all other outputs are registered.

## Configuration
- **`RF_WB_BYPASS_EN`** adds ports `byp_hit1`, `byp_hit2` (1 bit) and `byp_sca`, `byp_vec`.
  - When `rf_we`=1 and `rf_a3` matches `q_addrX`, `byp_hitX`=1, `busyX` is forced to 0, and the bypass data equals the staged write. The issue stage proceeds one cycle earlier, in cycle N+1.
  - Without the macro these ports do not exist and the timing is exactly as stated above.

## Structure
- **Package `rf_pkg`:**
  - constants NREGS=24, SCA_REGS=16, VEC_BASE=16, ADDR_W, DATA_W, LANES
  - typedefs `sca_t`, `vec_t` (packed LANES×DATA_W), and `wb_req_t` (addr, sca, vec)
  - function `is_vec(addr)`
- **Sub-module `rr_arbiter`:** parameterised by NREQ; inputs req, outputs one-hot grant; holds `ptr`.
- The top level contains the output stage, scoreboard and error flag.

## Test plan
- **Single write.** Reset, then req0 valid with addr 1, sca 4'hF. Expected: ready0=1 at once; next cycle rf_we=1, rf_a3=1, rf_wd_sca=F; then rf_we=0.
- **Round-robin order.** All three requesters valid for 4 cycles, with addrs 2, 16, 3. Expected: grants 0,1,2,0; the rf_a3 sequence is 2, 16, 3, 2, each delayed by one cycle.
- **Vector write.** req1 with addr 17, vec {C,A}. Expected: rf_wd_vec={4'hC,4'hA} and rf_wd_sca=0.
- **Scoreboard.** iss_set with addr 5, then q_addr1=5. Expected: busy1=1 and stall=1. After a write-back to 5: busy1=0 two cycles after the handshake; with RF_WB_BYPASS_EN, byp_hit1=1 and busy1=0 one cycle after the handshake.
- **Set/clear collision.** iss_set addr 5 on the same edge as the commit to 5. Expected: busy[5] remains 1.
- **Invalid address and reset.** A request with addr 30 gives ready=1, rf_we stays 0, and err=1 (sticky). Asserting rst low while rf_we=1 clears all outputs immediately and clears err.
